deco_exe_stage: RTL and testbench

- Decode-to-execute pipeline boundary. Registers the control bundle from the decode control unit, plus operands, immediate and destination register, into the execute stage.
- Owns pipeline interlock: flush on a taken branch, a one-bubble load-use stall, and a multi-cycle hold while a SIN/COS op occupies execute.
- Drives the stall request back to fetch and decode.

---
 rtl/deco_exe_stage_pkg.sv | 47 ++++
 rtl/deco_exe_stage_hazard_detect.sv | 28 ++
 rtl/deco_exe_stage.sv | 175 +++++++++++++++++
 tb/tb_deco_exe_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deco_exe_stage_pkg.sv
// Shared type and helper definitions for the decode-to-execute boundary.
//   stages_definition_pkg : control bundle carried from decode to execute.
//   cu_definitions_pkg    : interlock state encoding, memToReg codes and
//                           small classification helpers.
// Optional feature macro used by the stage: DECO_EXE_PERF_EN.

package stages_definition_pkg;

    // Control bundle produced by the decode control unit.
    // The all-zero value is the NOP encoding.
    typedef struct packed {
        logic       regWrite;
        logic [1:0] memToReg;
        logic       memWrite;
        logic       branch;
        logic       aluSrc;
        logic [3:0] aluControl;
        logic       trigControl;
    } deco_exe_cu_signals;

endpackage

package cu_definitions_pkg;

    import stages_definition_pkg::*;

    // Interlock state of the decode/execute boundary
    typedef enum logic [0:0] {
        RUN       = 1'b0,
        TRIG_WAIT = 1'b1
    } deco_exe_state_t;

    // memToReg selects write-back source: memory data or trig unit result
    localparam logic [1:0] MEMTOREG_MEM  = 2'b00;
    localparam logic [1:0] MEMTOREG_TRIG = 2'b11;

    // SIN/COS instruction: writes a register from the trig unit
    function automatic logic is_trig(input deco_exe_cu_signals ctrl);
        return ctrl.regWrite && (ctrl.memToReg == MEMTOREG_TRIG);
    endfunction

    // Load instruction: writes a register from memory
    function automatic logic is_load(input deco_exe_cu_signals ctrl);
        return ctrl.regWrite && (ctrl.memToReg == MEMTOREG_MEM);
    endfunction

endpackage

// File: rtl/deco_exe_stage_hazard_detect.sv
// Load-use hazard detection. Purely combinational so that it can also be
// instantiated by the forwarding unit. Register r0 is deliberately not
// special-cased: a load to r0 followed by a use of r0 still interlocks.

module hazard_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  e_valid,
    input  logic                  e_load,
    input  logic [REG_ADDR_W-1:0] e_wa,
    input  logic                  d_valid,
    input  logic                  d_alu_src,
    input  logic [REG_ADDR_W-1:0] d_ra1,
    input  logic [REG_ADDR_W-1:0] d_ra2,
    output logic                  lu
);

    // Second source only matters when the ALU actually reads it (aluSrc=0)
    always_comb begin
        lu = 1'b0;
        if (e_valid && e_load && d_valid) begin
            lu = (e_wa == d_ra1) || ((e_wa == d_ra2) && !d_alu_src);
        end else begin
            lu = 1'b0;
        end
    end

endmodule

// File: rtl/deco_exe_stage.sv
// Decode-to-execute pipeline register with interlock control:
//   - flush on a taken branch (decode slot discarded),
//   - one-bubble load-use stall,
//   - multi-cycle hold while a SIN/COS op occupies execute.
// Optional performance counters are enabled by defining DECO_EXE_PERF_EN.

module deco_exe_stage
    import stages_definition_pkg::*;
    import cu_definitions_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int TRIG_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DECO_EXE_PERF_EN
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           trig_hold_cnt,
`endif
    input  deco_exe_cu_signals    d_ctrl,
    input  logic                  d_valid,
    input  logic [DATA_W-1:0]     d_rd1,
    input  logic [DATA_W-1:0]     d_rd2,
    input  logic [DATA_W-1:0]     d_imm,
    input  logic [REG_ADDR_W-1:0] d_ra1,
    input  logic [REG_ADDR_W-1:0] d_ra2,
    input  logic [REG_ADDR_W-1:0] d_wa,
    input  logic                  flush,
    output deco_exe_cu_signals    e_ctrl,
    output logic                  e_valid,
    output logic [DATA_W-1:0]     e_rd1,
    output logic [DATA_W-1:0]     e_rd2,
    output logic [DATA_W-1:0]     e_imm,
    output logic [REG_ADDR_W-1:0] e_wa,
    output logic                  stall_fd,
    output logic                  trig_busy
);

    // Counter holds the number of extra wait edges; TRIG_LAT<=16 fits in 4 bits
    localparam int CNT_W    = 4;
    localparam int CNT_INIT = (TRIG_LAT > 1) ? (TRIG_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_START = CNT_INIT[CNT_W-1:0];

    deco_exe_state_t  state;
    logic [CNT_W-1:0] trig_cnt;
    logic             lu;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .e_valid   (e_valid),
        .e_load    (is_load(e_ctrl)),
        .e_wa      (e_wa),
        .d_valid   (d_valid),
        .d_alu_src (d_ctrl.aluSrc),
        .d_ra1     (d_ra1),
        .d_ra2     (d_ra2),
        .lu        (lu)
    );

    // Stall request is combinational so fetch/decode freeze in the same cycle
    always_comb begin
        stall_fd = 1'b0;
        if (state == TRIG_WAIT) begin
            stall_fd = 1'b1;
        end else begin
            stall_fd = lu && !flush;
        end
    end

    assign trig_busy = (state == TRIG_WAIT);

    // Interlock FSM together with the execute-stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            trig_cnt <= {CNT_W{1'b0}};
            e_valid  <= 1'b0;
            e_ctrl   <= '0;
            e_rd1    <= {DATA_W{1'b0}};
            e_rd2    <= {DATA_W{1'b0}};
            e_imm    <= {DATA_W{1'b0}};
            e_wa     <= {REG_ADDR_W{1'b0}};
        end else begin
            case (state)
                RUN: begin
                    if (flush || lu || !d_valid) begin
                        // Bubble: flush wins over lu; no instruction otherwise
                        e_valid <= 1'b0;
                        e_ctrl  <= '0;
                        e_rd1   <= {DATA_W{1'b0}};
                        e_rd2   <= {DATA_W{1'b0}};
                        e_imm   <= {DATA_W{1'b0}};
                        e_wa    <= {REG_ADDR_W{1'b0}};
                    end else begin
                        e_valid <= 1'b1;
                        e_ctrl  <= d_ctrl;
                        e_rd1   <= d_rd1;
                        e_rd2   <= d_rd2;
                        e_imm   <= d_imm;
                        e_wa    <= d_wa;
                        if (is_trig(d_ctrl) && (TRIG_LAT > 1)) begin
                            state    <= TRIG_WAIT;
                            trig_cnt <= CNT_START;
                        end else begin
                            state    <= RUN;
                        end
                    end
                end
                TRIG_WAIT: begin
                    if (flush) begin
                        // Abort the wait; trig op is squashed by the branch
                        state    <= RUN;
                        trig_cnt <= {CNT_W{1'b0}};
                        e_valid  <= 1'b0;
                        e_ctrl   <= '0;
                        e_rd1    <= {DATA_W{1'b0}};
                        e_rd2    <= {DATA_W{1'b0}};
                        e_imm    <= {DATA_W{1'b0}};
                        e_wa     <= {REG_ADDR_W{1'b0}};
                    end else if (trig_cnt == {CNT_W{1'b0}}) begin
                        state <= RUN;
                    end else begin
                        trig_cnt <= trig_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state    <= RUN;
                    trig_cnt <= {CNT_W{1'b0}};
                    e_valid  <= 1'b0;
                    e_ctrl   <= '0;
                    e_rd1    <= {DATA_W{1'b0}};
                    e_rd2    <= {DATA_W{1'b0}};
                    e_imm    <= {DATA_W{1'b0}};
                    e_wa     <= {REG_ADDR_W{1'b0}};
                end
            endcase
        end
    end

`ifdef DECO_EXE_PERF_EN
    logic hazard_bubble;

    // A hazard bubble is one caused by flush (either state) or by load-use
    always_comb begin
        hazard_bubble = 1'b0;
        if (state == TRIG_WAIT) begin
            hazard_bubble = flush;
        end else begin
            hazard_bubble = flush || lu;
        end
    end

    // Free-running wrap-around performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt    <= 32'd0;
            trig_hold_cnt <= 32'd0;
        end else begin
            if (hazard_bubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end else begin
                bubble_cnt <= bubble_cnt;
            end
            if (state == TRIG_WAIT) begin
                trig_hold_cnt <= trig_hold_cnt + 32'd1;
            end else begin
                trig_hold_cnt <= trig_hold_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_deco_exe_stage.sv
// Self-checking bench for deco_exe_stage: a cycle-level behavioural model
// (execute slot plus "cycles left in hold") checked every cycle, and
// directed sequences with hand-computed literal expectations.

module tb_deco_exe_stage;
    import stages_definition_pkg::*;
    import cu_definitions_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int TL = 4;

    localparam deco_exe_cu_signals C_NOP = '0;
    localparam deco_exe_cu_signals C_ADD = '{regWrite:1'b1, memToReg:2'b01, memWrite:1'b0,
        branch:1'b0, aluSrc:1'b0, aluControl:4'b0010, trigControl:1'b0};
    localparam deco_exe_cu_signals C_LW  = '{regWrite:1'b1, memToReg:2'b00, memWrite:1'b0,
        branch:1'b0, aluSrc:1'b1, aluControl:4'b0010, trigControl:1'b0};
    localparam deco_exe_cu_signals C_SUB = '{regWrite:1'b1, memToReg:2'b01, memWrite:1'b0,
        branch:1'b0, aluSrc:1'b0, aluControl:4'b0110, trigControl:1'b0};
    localparam deco_exe_cu_signals C_SBI = '{regWrite:1'b1, memToReg:2'b01, memWrite:1'b0,
        branch:1'b0, aluSrc:1'b1, aluControl:4'b0110, trigControl:1'b0};
    localparam deco_exe_cu_signals C_COS = '{regWrite:1'b1, memToReg:2'b11, memWrite:1'b0,
        branch:1'b0, aluSrc:1'b0, aluControl:4'b0000, trigControl:1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    deco_exe_cu_signals d_ctrl = '0;
    logic d_valid = 1'b0;
    logic [DW-1:0] d_rd1 = '0, d_rd2 = '0, d_imm = '0;
    logic [AW-1:0] d_ra1 = '0, d_ra2 = '0, d_wa = '0;
    logic flush = 1'b0;
    deco_exe_cu_signals e_ctrl;
    logic e_valid;
    logic [DW-1:0] e_rd1, e_rd2, e_imm;
    logic [AW-1:0] e_wa;
    logic stall_fd, trig_busy;
`ifdef DECO_EXE_PERF_EN
    logic [31:0] bubble_cnt, trig_hold_cnt;
`endif

    int checks = 0;
    int errors = 0;

    deco_exe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .TRIG_LAT(TL)) dut (
        .clk(clk),
        .rst(rst),
`ifdef DECO_EXE_PERF_EN
        .bubble_cnt(bubble_cnt),
        .trig_hold_cnt(trig_hold_cnt),
`endif
        .d_ctrl(d_ctrl), .d_valid(d_valid),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm),
        .d_ra1(d_ra1), .d_ra2(d_ra2), .d_wa(d_wa),
        .flush(flush),
        .e_ctrl(e_ctrl), .e_valid(e_valid),
        .e_rd1(e_rd1), .e_rd2(e_rd2), .e_imm(e_imm), .e_wa(e_wa),
        .stall_fd(stall_fd), .trig_busy(trig_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic               m_valid;
    deco_exe_cu_signals m_ctrl;
    logic [DW-1:0]      m_rd1, m_rd2, m_imm;
    logic [AW-1:0]      m_wa;
    int                 m_hold;      // remaining cycles execute stays frozen
    logic [31:0]        m_bub, m_trig;

    function automatic logic m_lu();
        return m_valid && m_ctrl.regWrite && (m_ctrl.memToReg == 2'b00) && d_valid &&
               ((m_wa == d_ra1) || ((m_wa == d_ra2) && !d_ctrl.aluSrc));
    endfunction

    task automatic m_clear();
        m_valid = 1'b0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_wa = '0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clear();
            m_hold = 0; m_bub = 32'd0; m_trig = 32'd0;
        end else if (m_hold > 0) begin
            m_trig = m_trig + 32'd1;
            if (flush) begin
                m_clear(); m_hold = 0; m_bub = m_bub + 32'd1;
            end else begin
                m_hold = m_hold - 1;
            end
        end else if (flush || m_lu()) begin
            m_clear(); m_bub = m_bub + 32'd1;
        end else if (d_valid) begin
            m_valid = 1'b1; m_ctrl = d_ctrl; m_rd1 = d_rd1; m_rd2 = d_rd2;
            m_imm = d_imm; m_wa = d_wa;
            if (d_ctrl.regWrite && d_ctrl.memToReg == 2'b11) m_hold = TL - 1;
        end else begin
            m_clear();
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("m_e_valid", {31'd0, e_valid}, {31'd0, m_valid});
        chk("m_e_ctrl", {21'd0, e_ctrl}, {21'd0, m_ctrl});
        chk("m_e_rd1", e_rd1, m_rd1);
        chk("m_e_rd2", e_rd2, m_rd2);
        chk("m_e_imm", e_imm, m_imm);
        chk("m_e_wa", {28'd0, e_wa}, {28'd0, m_wa});
        chk("m_stall_fd", {31'd0, stall_fd},
            {31'd0, (m_hold > 0) || (m_lu() && !flush && !rst)});
        chk("m_trig_busy", {31'd0, trig_busy}, {31'd0, (m_hold > 0)});
`ifdef DECO_EXE_PERF_EN
        chk("m_bubble_cnt", bubble_cnt, m_bub);
        chk("m_trig_hold_cnt", trig_hold_cnt, m_trig);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input deco_exe_cu_signals c,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] w, input logic [DW-1:0] base);
        d_valid = v; d_ctrl = c; d_ra1 = a1; d_ra2 = a2; d_wa = w;
        d_rd1 = base; d_rd2 = base + 32'd1; d_imm = base + 32'd2;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_e_valid", {31'd0, e_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall_fd}, 32'd0);
        rst = 1'b0;

        // Plain ADD, no hazards
        drive(1'b1, C_ADD, 4'd1, 4'd2, 4'd3, 32'h100); step();
        chk("add_valid", {31'd0, e_valid}, 32'd1);
        chk("add_aluc", {28'd0, e_ctrl.aluControl}, 32'h2);
        chk("add_wa", {28'd0, e_wa}, 32'd3);
        chk("add_rd1", e_rd1, 32'h100);
        chk("add_stall", {31'd0, stall_fd}, 32'd0);

        // Load r5, then SUB reading r5 via ra1: one bubble
        drive(1'b1, C_LW, 4'd1, 4'd0, 4'd5, 32'h200); step();
        drive(1'b1, C_SUB, 4'd5, 4'd6, 4'd7, 32'h300); #1;
        chk("lu_ra1_stall", {31'd0, stall_fd}, 32'd1);
        step();
        chk("lu_bubble", {31'd0, e_valid}, 32'd0);
        chk("lu_stall_drop", {31'd0, stall_fd}, 32'd0);
        step();
        chk("lu_sub_valid", {31'd0, e_valid}, 32'd1);
        chk("lu_sub_aluc", {28'd0, e_ctrl.aluControl}, 32'h6);
        chk("lu_sub_wa", {28'd0, e_wa}, 32'd7);

        // Load r5, then immediate-form SUB with ra2=5: no stall
        drive(1'b1, C_LW, 4'd1, 4'd0, 4'd5, 32'h400); step();
        drive(1'b1, C_SBI, 4'd2, 4'd5, 4'd8, 32'h500); #1;
        chk("lu_ra2_imm_nostall", {31'd0, stall_fd}, 32'd0);
        step();
        chk("ra2_imm_wa", {28'd0, e_wa}, 32'd8);

        // COS holds execute for TL cycles, stall for TL-1
        drive(1'b1, C_COS, 4'd1, 4'd2, 4'd9, 32'h600); step();
        drive(1'b1, C_ADD, 4'd1, 4'd2, 4'd10, 32'h700);
        for (int i = 0; i < TL - 1; i++) begin
            #1;
            chk("cos_stall", {31'd0, stall_fd}, 32'd1);
            chk("cos_busy", {31'd0, trig_busy}, 32'd1);
            chk("cos_hold_wa", {28'd0, e_wa}, 32'd9);
            step();
        end
        #1;
        chk("cos_end_stall", {31'd0, stall_fd}, 32'd0);
        chk("cos_end_wa", {28'd0, e_wa}, 32'd9);
        step();
        chk("cos_next_wa", {28'd0, e_wa}, 32'd10);

        // Back-to-back COS: second loads on the RUN edge after first wait
        drive(1'b1, C_COS, 4'd1, 4'd2, 4'd11, 32'h800); step();
        drive(1'b1, C_COS, 4'd1, 4'd2, 4'd12, 32'h900);
        repeat (TL) step();
        chk("b2b_second_wa", {28'd0, e_wa}, 32'd12);
        drive(1'b0, C_NOP, 4'd0, 4'd0, 4'd0, 32'h0);
        repeat (TL) step();

        // flush together with lu: flush wins, no stall
        drive(1'b1, C_LW, 4'd1, 4'd0, 4'd4, 32'ha00); step();
        drive(1'b1, C_ADD, 4'd4, 4'd2, 4'd13, 32'hb00); flush = 1'b1; #1;
        chk("flush_lu_stall", {31'd0, stall_fd}, 32'd0);
        step();
        chk("flush_lu_bubble", {31'd0, e_valid}, 32'd0);
        chk("flush_lu_ctrl", {21'd0, e_ctrl}, 32'd0);
        flush = 1'b0;

        // flush during TRIG_WAIT aborts the hold
        drive(1'b1, C_COS, 4'd1, 4'd2, 4'd14, 32'hc00); step();
        drive(1'b1, C_ADD, 4'd1, 4'd2, 4'd15, 32'hd00); step();
        flush = 1'b1; step();
        flush = 1'b0; #1;
        chk("flush_trig_busy", {31'd0, trig_busy}, 32'd0);
        chk("flush_trig_valid", {31'd0, e_valid}, 32'd0);
        chk("flush_trig_stall", {31'd0, stall_fd}, 32'd0);
        step();

        // Reset while counter is 2
        drive(1'b1, C_COS, 4'd1, 4'd2, 4'd6, 32'he00); step();
        drive(1'b0, C_NOP, 4'd0, 4'd0, 4'd0, 32'h0);
        rst = 1'b1; #1;
        chk("rstmid_valid", {31'd0, e_valid}, 32'd0);
        chk("rstmid_ctrl", {21'd0, e_ctrl}, 32'd0);
        chk("rstmid_stall", {31'd0, stall_fd}, 32'd0);
        chk("rstmid_busy", {31'd0, trig_busy}, 32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, C_ADD, 4'd1, 4'd2, 4'd3, 32'hf00); step();
        chk("rstmid_add_valid", {31'd0, e_valid}, 32'd1);
        chk("rstmid_add_wa", {28'd0, e_wa}, 32'd3);

        // Load to r0 then use r0 still stalls
        drive(1'b1, C_LW, 4'd1, 4'd0, 4'd0, 32'h1000); step();
        drive(1'b1, C_SUB, 4'd0, 4'd1, 4'd2, 32'h1100); #1;
        chk("r0_stall", {31'd0, stall_fd}, 32'd1);
        repeat (2) step();
        drive(1'b0, C_NOP, 4'd0, 4'd0, 4'd0, 32'h0);
        step();

`ifdef DECO_EXE_PERF_EN
        // Counters: one load-use bubble and one COS at TL=4
        rst = 1'b1; step(); rst = 1'b0;
        chk("perf_rst_bub", bubble_cnt, 32'd0);
        drive(1'b1, C_LW, 4'd1, 4'd0, 4'd5, 32'h2000); step();
        drive(1'b1, C_SUB, 4'd5, 4'd6, 4'd7, 32'h2100); repeat (2) step();
        drive(1'b1, C_COS, 4'd1, 4'd2, 4'd9, 32'h2200); step();
        drive(1'b0, C_NOP, 4'd0, 4'd0, 4'd0, 32'h0); repeat (TL) step();
        chk("perf_bubble_cnt", bubble_cnt, 32'd1);
        chk("perf_trig_hold_cnt", trig_hold_cnt, 32'd3);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
